// File: rtl/fuzz_seq_pkg.sv
// Shared types and helpers for the fuzz stimulus sequencer: LCG constants,
// FSM state encoding, the LCG step function and the response-folding function.
package fuzz_seq_pkg;

  localparam logic [31:0] LCG_A_DEF = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_C_DEF = 32'h0000_3039;

  // Widest response the folding helper accepts; narrower responses are zero-extended.
  localparam int FOLD_MAX_W = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_GEN,
    S_APPLY,
    S_DONE
  } seq_state_e;

  function automatic logic [31:0] lcg_next(input logic [31:0] x,
                                           input logic [31:0] a = LCG_A_DEF,
                                           input logic [31:0] c = LCG_C_DEF);
    return x * a + c;
  endfunction

  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] v);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < FOLD_MAX_W / 32; k++) begin
      acc ^= v[k*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/fuzz_stim_sequencer_lcg.sv
// fuzz_lcg32: 32-bit LCG state register with seed load and single-step advance.
// next_o is the value the register takes on the next step, i.e. the next word.
module fuzz_lcg32
  import fuzz_seq_pkg::*;
#(
  parameter logic [31:0] A = LCG_A_DEF,
  parameter logic [31:0] C = LCG_C_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  output logic [31:0] next_o
);

  logic [31:0] state_q;

  assign next_o = lcg_next(state_q, A, C);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (step_i) begin
      state_q <= next_o;
    end
  end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Stimulus sequencer: resets the DUT, streams LCG-generated vectors into it and
// compresses its responses into a MISR signature. Optional trace: FUZZ_SEQ_TRACE_EN.
module fuzz_stim_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int          IN_W        = 263,
  parameter int          OUT_W       = 330,
  parameter logic [31:0] LCG_A       = LCG_A_DEF,
  parameter logic [31:0] LCG_C       = LCG_C_DEF,
  parameter int          DUT_RST_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       seed,
  input  logic [31:0]       cycles,
  output logic              dut_rst_n,
  output logic [IN_W-1:0]   dut_in_flat,
  input  logic [OUT_W-1:0]  dut_out_flat,
  output logic              vec_apply,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       signature,
  output logic              busy,
  output logic              done
);

  localparam int NW     = (IN_W + 31) / 32;
  localparam int LAST_W = IN_W - 32 * (NW - 1);
  localparam int WIDX_W = $clog2(NW + 1);
  localparam int RCNT_W = $clog2(DUT_RST_CYC + 1);

  seq_state_e        state_q, state_d;
  logic [31:0]       limit_q, limit_d;
  logic [31:0]       cyc_cnt_q, cyc_cnt_d;
  logic [31:0]       sig_q, sig_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [IN_W-1:0]   shadow_q, shadow_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic              vec_apply_q, vec_apply_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fold_pend_q, fold_pend_d;

  logic              lcg_load, lcg_step;
  logic [31:0]       lcg_word;
  logic [FOLD_MAX_W-1:0] out_ext;
  logic [31:0]       sig_step;
  logic [32:0]       cnt_next, lim_end;

  fuzz_lcg32 #(
    .A(LCG_A),
    .C(LCG_C)
  ) u_lcg (
    .clk    (clk),
    .rst    (rst),
    .load_i (lcg_load),
    .step_i (lcg_step),
    .seed_i (seed),
    .next_o (lcg_word)
  );

  always_comb begin
    out_ext               = '0;
    out_ext[OUT_W-1:0]    = dut_out_flat;
    sig_step              = {sig_q[30:0], sig_q[31]} ^ fold32(out_ext);
    // 33-bit compare keeps cycles = 32'hFFFFFFFF from wrapping the end point.
    cnt_next              = {1'b0, cyc_cnt_q} + 33'd1;
    lim_end               = {1'b0, limit_q} + 33'd1;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    limit_d     = limit_q;
    cyc_cnt_d   = cyc_cnt_q;
    sig_d       = sig_q;
    widx_d      = widx_q;
    rcnt_d      = rcnt_q;
    shadow_d    = shadow_q;
    dut_in_d    = dut_in_q;
    vec_apply_d = 1'b0;
    dut_rst_n_d = dut_rst_n_q;
    fold_pend_d = fold_pend_q;
    lcg_load    = 1'b0;
    lcg_step    = 1'b0;
    // Status lags state by one clock so done rises with the final signature fold.
    busy_d      = (state_q == S_DRST) || (state_q == S_GEN) || (state_q == S_APPLY);
    done_d      = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_DRST;
          lcg_load    = 1'b1;
          limit_d     = cycles;
          cyc_cnt_d   = '0;
          sig_d       = '0;
          widx_d      = '0;
          rcnt_d      = '0;
          done_d      = 1'b0;
          dut_rst_n_d = 1'b0;
          fold_pend_d = 1'b0;
        end else if (fold_pend_q) begin
          sig_d       = sig_step;
          fold_pend_d = 1'b0;
        end
      end

      S_DRST: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          // Word generation overlaps the DUT reset; the last word is left to GEN.
          if (widx_q < WIDX_W'(NW - 1)) begin
            lcg_step = 1'b1;
            widx_d   = widx_q + 1'b1;
          end
          if (rcnt_q == RCNT_W'(DUT_RST_CYC - 1)) begin
            state_d     = S_GEN;
            dut_rst_n_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end

      S_GEN: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          lcg_step = 1'b1;
          if (widx_q == WIDX_W'(NW - 1)) begin
            widx_d  = '0;
            state_d = S_APPLY;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end

      S_APPLY: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          dut_in_d    = shadow_q;
          vec_apply_d = 1'b1;
          if (cyc_cnt_q != '0) sig_d = sig_step;
          cyc_cnt_d   = cnt_next[31:0];
          if (cnt_next == lim_end) begin
            state_d     = S_DONE;
            fold_pend_d = 1'b1;
          end else begin
            state_d = S_GEN;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (lcg_step) begin
      for (int k = 0; k < NW - 1; k++) begin
        if (widx_q == WIDX_W'(k)) shadow_d[k*32 +: 32] = lcg_word;
      end
      if (widx_q == WIDX_W'(NW - 1)) shadow_d[IN_W-1 -: LAST_W] = lcg_word[LAST_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      limit_q     <= '0;
      cyc_cnt_q   <= '0;
      sig_q       <= '0;
      widx_q      <= '0;
      rcnt_q      <= '0;
      dut_in_q    <= '0;
      vec_apply_q <= 1'b0;
      dut_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fold_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      cyc_cnt_q   <= cyc_cnt_d;
      sig_q       <= sig_d;
      widx_q      <= widx_d;
      rcnt_q      <= rcnt_d;
      dut_in_q    <= dut_in_d;
      vec_apply_q <= vec_apply_d;
      dut_rst_n_q <= dut_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fold_pend_q <= fold_pend_d;
    end
  end

  // NOTE: the shadow vector is deliberately not reset: every word is rewritten
  // before it can reach dut_in_flat, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign dut_rst_n   = dut_rst_n_q;
  assign dut_in_flat = dut_in_q;
  assign vec_apply   = vec_apply_q;
  assign cyc_cnt     = cyc_cnt_q;
  assign signature   = sig_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef FUZZ_SEQ_TRACE_EN
  always @(posedge clk) begin
    if (!rst && vec_apply_q) begin
      $display("CYCLE=%0d IN=%0h OUT=%0h", cyc_cnt_q, dut_in_q, dut_out_flat);
    end
    if (!rst && state_q != S_DONE && state_d == S_DONE) begin
      $display("TB_SIM_OK cycles=%0d", cyc_cnt_d);
    end
  end
`else
  // Trace disabled: the build carries no simulation-only code.
`endif

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Scoreboard bench for fuzz_stim_sequencer: a queue-based LCG/MISR reference model
// feeds expected applies to a monitor; run-level results are checked at completion.
module tb_fuzz_stim_sequencer;

  localparam int          IN_W  = 263;
  localparam int          OUT_W = 330;
  localparam int          NW    = 9;
  localparam logic [31:0] LCG_A = 32'h41C64E6D;
  localparam logic [31:0] LCG_C = 32'h00003039;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [31:0]       seed = '0;
  logic [31:0]       cycles = '0;
  logic              dut_rst_n;
  logic [IN_W-1:0]   dut_in_flat;
  logic [OUT_W-1:0]  dut_out_flat;
  logic              vec_apply;
  logic [31:0]       cyc_cnt;
  logic [31:0]       signature;
  logic              busy;
  logic              done;
  logic [OUT_W-IN_W-1:0] out_hi = '0;

  // Loopback DUT: response is the applied vector with a run-constant upper pattern.
  assign dut_out_flat = {out_hi, dut_in_flat};

  always #5 clk = ~clk;

  fuzz_stim_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .seed         (seed),
    .cycles       (cycles),
    .dut_rst_n    (dut_rst_n),
    .dut_in_flat  (dut_in_flat),
    .dut_out_flat (dut_out_flat),
    .vec_apply    (vec_apply),
    .cyc_cnt      (cyc_cnt),
    .signature    (signature),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [IN_W-1:0] vec;
    logic [31:0]     cnt;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            mon_e;
  logic [IN_W-1:0] exp_vecs[$];
  int              apply_cyc[$];
  int              cyc_no = 0;
  int              n_checks = 0;
  int              n_errors = 0;
  int              done_rise_cyc = -1;
  int              busy_fall_cyc = -1;
  logic            done_prev = 1'b0;
  logic            busy_prev = 1'b0;

  task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_no++;

  // Monitor: every vec_apply pops one expected apply from the scoreboard.
  always @(negedge clk) begin
    if (vec_apply === 1'b1) begin
      apply_cyc.push_back(cyc_no);
      if (sb_q.size() == 0) begin
        check("unexpected_apply", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("apply_vector", dut_in_flat, mon_e.vec);
        check("apply_cyc_cnt", cyc_cnt, mon_e.cnt);
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc_no;
    if (busy === 1'b0 && busy_prev === 1'b1) busy_fall_cyc = cyc_no;
    done_prev = done;
    busy_prev = busy;
  end

  // Reference model: the run's vectors are consecutive 9-word slices of the LCG stream.
  function automatic void build_run(input logic [31:0] s, input int n_vec);
    logic [31:0]     x;
    logic [NW*32-1:0] w;
    exp_vecs.delete();
    x = s;
    for (int v = 0; v < n_vec; v++) begin
      for (int k = 0; k < NW; k++) begin
        x = x * LCG_A + LCG_C;
        w[k*32 +: 32] = x;
      end
      exp_vecs.push_back(w[IN_W-1:0]);
    end
  endfunction

  function automatic logic [31:0] fold_model(input logic [OUT_W-1:0] o);
    logic [351:0] p;
    logic [31:0]  acc;
    p = '0;
    p[OUT_W-1:0] = o;
    acc = '0;
    for (int k = 0; k < 11; k++) acc ^= p[k*32 +: 32];
    return acc;
  endfunction

  // Each response folded once, in apply order, into a rotate-left-by-one MISR.
  function automatic logic [31:0] model_sig(input int n_fold);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n_fold; i++) begin
      s = {s[30:0], s[31]} ^ fold_model({out_hi, exp_vecs[i]});
    end
    return s;
  endfunction

  task automatic push_expect(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.vec = exp_vecs[i];
      e.cnt = 32'(i + 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] c);
    apply_cyc.delete();
    done_rise_cyc = -1;
    busy_fall_cyc = -1;
    seed   = s;
    cycles = c;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_dut_rst_n", dut_rst_n, 0);
    check("rst_dut_in_flat", dut_in_flat, 0);
    check("rst_vec_apply", vec_apply, 0);
    check("rst_cyc_cnt", cyc_cnt, 0);
    check("rst_signature", signature, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  initial begin
    logic [31:0] s;
    logic [95:0] r96;
    int          lo;
    int          n;
    int          c;

    repeat (3) step();
    check_reset_vals();
    rst = 1'b0;
    step();

    // Known first words from seed 0, single vector.
    build_run(32'd0, 1);
    push_expect(1);
    start_run(32'd0, 32'd0);
    wait_done(40);
    check("s1_word0", dut_in_flat[31:0], 32'h00003039);
    check("s1_word1", dut_in_flat[63:32], 32'hD3DC167E);
    check("s1_apply_count", apply_cyc.size(), 1);
    check("s1_cyc_cnt", cyc_cnt, 1);
    if (apply_cyc.size() > 0) check("s1_done_after_apply", done_rise_cyc - apply_cyc[0], 1);
    check("s1_sig", signature, model_sig(1));
    check("s1_sb_empty", sb_q.size(), 0);

    // Timing: DUT reset width, apply period, busy/done handover.
    s = 32'd4161807235;
    build_run(s, 4);
    push_expect(4);
    start_run(s, 32'd3);
    lo = 0;
    while (dut_rst_n === 1'b0 && lo < 20) begin
      lo++;
      step();
    end
    check("s2_dut_rst_low_cycles", lo, 2);
    wait_done(100);
    check("s2_apply_count", apply_cyc.size(), 4);
    for (int i = 1; i < apply_cyc.size(); i++) begin
      check("s2_apply_spacing", apply_cyc[i] - apply_cyc[i-1], 10);
    end
    check("s2_cyc_cnt", cyc_cnt, 4);
    check("s2_busy_fall_eq_done_rise", busy_fall_cyc, done_rise_cyc);
    check("s2_busy_low", busy, 0);
    check("s2_sig", signature, model_sig(4));
    check("s2_sb_empty", sb_q.size(), 0);

    // Signature over a loopback run, then the same seed again.
    out_hi = '0;
    s = $urandom;
    for (int rep = 0; rep < 2; rep++) begin
      build_run(s, 6);
      push_expect(6);
      start_run(s, 32'd5);
      wait_done(200);
      check("s3_sig", signature, model_sig(6));
      check("s3_cyc_cnt", cyc_cnt, 6);
      check("s3_sb_empty", sb_q.size(), 0);
    end

    // Stop during generation of the third vector.
    s = $urandom;
    build_run(s, 6);
    push_expect(2);
    start_run(s, 32'd5);
    n = 0;
    while (apply_cyc.size() < 2 && n < 100) begin
      step();
      n++;
    end
    check("s4_two_applies_before_stop", apply_cyc.size(), 2);
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(10);
    repeat (20) step();
    check("s4_apply_count", apply_cyc.size(), 2);
    check("s4_cyc_cnt", cyc_cnt, 2);
    check("s4_in_held", dut_in_flat, exp_vecs[1]);
    check("s4_sig_no_final_fold", signature, model_sig(1));
    check("s4_busy_low", busy, 0);
    check("s4_sb_empty", sb_q.size(), 0);

    // Start while busy is ignored; stop while done is ignored.
    s = $urandom;
    build_run(s, 3);
    push_expect(3);
    start_run(s, 32'd2);
    repeat (4) step();
    seed   = ~s;
    cycles = 32'd0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    wait_done(100);
    check("s5_apply_count", apply_cyc.size(), 3);
    check("s5_cyc_cnt", cyc_cnt, 3);
    check("s5_sig", signature, model_sig(3));
    check("s5_sb_empty", sb_q.size(), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (3) step();
    check("s5_done_after_stop", done, 1);
    check("s5_cyc_cnt_after_stop", cyc_cnt, 3);

    // Reset asserted during the APPLY cycle of the second vector.
    s = $urandom;
    build_run(s, 4);
    push_expect(4);
    start_run(s, 32'd3);
    n = 0;
    while (apply_cyc.size() < 1 && n < 40) begin
      step();
      n++;
    end
    check("s6_first_apply", apply_cyc.size(), 1);
    repeat (9) step();
    rst = 1'b1;
    step();
    check_reset_vals();
    rst = 1'b0;
    sb_q.delete();
    step();
    build_run(32'd0, 1);
    push_expect(1);
    start_run(32'd0, 32'd0);
    wait_done(40);
    check("s6_word0_after_rst", dut_in_flat[31:0], 32'h00003039);
    check("s6_cyc_cnt", cyc_cnt, 1);
    check("s6_sb_empty", sb_q.size(), 0);

    // Random runs with a non-zero upper response pattern.
    for (int r = 0; r < 4; r++) begin
      r96    = {$urandom, $urandom, $urandom};
      out_hi = r96[OUT_W-IN_W-1:0];
      s      = $urandom;
      c      = $urandom_range(0, 3);
      build_run(s, c + 1);
      push_expect(c + 1);
      start_run(s, 32'(c));
      wait_done(100);
      check("s7_sig", signature, model_sig(c + 1));
      check("s7_cyc_cnt", cyc_cnt, c + 1);
      check("s7_sb_empty", sb_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fuzz_stim_sequencer.md
Name: fuzz_stim_sequencer

Overview:
Synthesizable stimulus sequencer for the flat-vector fuzz harness. It drives the DUT reset, generates deterministic pseudo-random input vectors from a 32-bit LCG, and applies a new vector for a programmed number of cycles. It also compresses DUT outputs into a 32-bit signature. Results are bit-identical across simulators and FPGA emulation for a given seed. It sits between run control (host or tb) and the DUT's in_flat/out_flat ports.

Parameters:
IN_W, 263, DUT in_flat width
OUT_W, 330, DUT out_flat width
LCG_A, 32'h41C64E6D, LCG multiplier
LCG_C, 32'h3039, LCG increment
DUT_RST_CYC, 2, cycles dut_rst_n is held low at run start

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a run when IDLE or DONE
stop  in  1  pulse; aborts the run, next state DONE
seed  in  32  LCG seed, latched on start
cycles  in  32  number of vectors after the initial one, latched on start
dut_rst_n  out  1  DUT reset, active-low
dut_in_flat  out  IN_W  vector applied to the DUT
dut_out_flat  in  OUT_W  DUT response
vec_apply  out  1  1-cycle pulse when dut_in_flat changes
cyc_cnt  out  32  vectors applied so far
signature  out  32  MISR of sampled responses
busy  out  1  high in any state except IDLE/DONE
done  out  1  high in DONE until the next start or rst

Behaviour:
- Constant NW = ceil(IN_W/32), which is 9 at the default IN_W.
- Reset values: state=IDLE; dut_rst_n=0; dut_in_flat=0; vec_apply=0; cyc_cnt=0; signature=0; busy=0; done=0; lcg=0.
- FSM states are IDLE, DRST, GEN, APPLY and DONE.
- IDLE/DONE --start--> DRST:
  - Latch seed into lcg and cycles into the limit register.
  - Clear cyc_cnt, signature and word index, and clear done.
  - dut_rst_n=0.
- DRST: hold dut_rst_n=0 for DUT_RST_CYC cycles, then go to GEN. dut_rst_n=1 from GEN onward.
- DRST also runs the LCG concurrently, so the first vector's words begin generating immediately.
- LCG step is lcg <= lcg*LCG_A + LCG_C (mod 2^32). Exactly one step per generated word.
- Word k of a vector is written to shadow[32k+31:32k], for k=0..NW-1.
- The last word is truncated: shadow[IN_W-1:32(NW-1)] takes the low bits of the LCG output. For example, [262:256] takes word8[6:0].
- GEN spends NW cycles filling shadow, then goes to APPLY.
- APPLY (1 cycle):
  - dut_in_flat <= shadow and vec_apply=1.
  - If cyc_cnt != 0: signature <= {signature[30:0], signature[31]} XOR (XOR of all 32-bit chunks of dut_out_flat, last chunk zero-extended).
  - Then cyc_cnt <= cyc_cnt+1.
  - If the new cyc_cnt == limit+1, go to DONE; otherwise go to GEN.
- Total vectors applied per run = cycles+1. With cycles=0, exactly one vector is applied.
- Apply period is NW+1 clocks. dut_in_flat is stable between vec_apply pulses and never partially updated.
- On entering DONE, the last vector's response is folded once more into signature.
- DONE holds dut_in_flat; busy=0, done=1.
- start while busy is ignored. stop in IDLE/DONE is ignored.
- stop in DRST, GEN or APPLY goes to DONE next cycle:
  - No further apply and no final fold.
  - dut_in_flat holds its value.
- If start and stop occur in the same cycle, start wins.
- rst mid-run returns all state to reset values on the next edge.
- cycles=32'hFFFFFFFF: the counter compare is performed in 33 bits, so the limit never wraps.

Optional Feature:
Macro FUZZ_SEQ_TRACE_EN.
- Defined: on each vec_apply, a simulation-only block prints "CYCLE=%0d IN=%0h OUT=%0h" with cyc_cnt, the new vector and dut_out_flat. On entering DONE it prints "TB_SIM_OK cycles=%0d".
- Undefined: no system tasks; identical cycle behaviour.

Decomposition:
- Package fuzz_seq_pkg holds:
  - LCG_A_DEF and LCG_C_DEF.
  - The state enum typedef seq_state_e.
  - Function lcg_next(logic [31:0]).
  - Function fold32(OUT_W) as the chunk-XOR helper.
- One sub-module, fuzz_lcg32: a seed-load/step register holding the LCG state.

Test Plan:
- Words: seed=0, cycles=0, start → first vector word0=32'h00003039, word1=32'hD3DC167E. Exactly one vec_apply; done high 1 cycle later; cyc_cnt=1.
- Timing: seed=4161807235, cycles=3 → dut_rst_n low exactly 2 cycles; 4 vec_apply pulses spaced 10 clocks apart; cyc_cnt=4; busy drops the same cycle done rises.
- Signature: loopback dut_out_flat = zero-extended dut_in_flat, cycles=5 → signature matches the reference model; re-running with the same seed reproduces an identical signature.
- Stop: stop during the GEN of vector 3 → DONE next cycle; cyc_cnt=2; no further apply; dut_in_flat unchanged.
- Ignored start: start pulsed while busy is ignored; the run completes normally.
- Reset mid-run: rst asserted in APPLY → all outputs return to their reset values next cycle. A subsequent start with the same seed yields the same first vector as the first scenario.
